sound_event_scheduler: RTL and testbench

- Sequences the music-score playback path for game sound effects (paddle hit, wall hit, point scored, game over).
- Latches one-cycle event requests and selects one by fixed priority.
- Issues a one-cycle Start with that event's score start address to the sheet reader, then waits for EndofScore before serving the next request.
- Sits between game logic and the reader / score memory / note player chain, and replaces the debounced push-button start.

---
 rtl/sound_event_scheduler.sv | 126 ++++++++++++
 tb/tb_sound_event_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_scheduler.sv
// Sound-effect playback scheduler: latches event pulses, grants one by fixed priority,
// starts the sheet reader at that score's address and waits for it to finish.
module sound_event_scheduler #(
  parameter int                     NumReq        = 4,
  parameter int                     AddressBits   = 5,
  parameter logic [AddressBits-1:0] Addr0         = 5'd0,
  parameter logic [AddressBits-1:0] Addr1         = 5'd8,
  parameter logic [AddressBits-1:0] Addr2         = 5'd16,
  parameter logic [AddressBits-1:0] Addr3         = 5'd24,
  parameter int                     TimeoutCycles = 8,
  parameter int                     GapCycles     = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NumReq-1:0]      Request,
  input  logic                   Mute,
  input  logic                   EndofScore,
  output logic                   Start,
  output logic [AddressBits-1:0] StartAddress,
  output logic [NumReq-1:0]      Grant,
  output logic                   Busy,
  output logic [NumReq-1:0]      Pending,
  output logic                   Timeout
);

  localparam int IdxBits = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    WAIT_BEGIN = 3'd2,
    PLAY       = 3'd3,
    GAP        = 3'd4
  } state_t;

  state_t state, state_next;

  logic [AddressBits-1:0] addr_table [NumReq];
  logic [IdxBits-1:0]     pick_idx;
  logic [NumReq-1:0]      pick_onehot;
  logic                   grant_now;
  logic                   timeout_hit;
  logic                   play_done;
  logic                   gap_done;
  logic [7:0]             timeout_cnt;
  logic [15:0]            gap_cnt;

  assign addr_table[0] = Addr0;
  assign addr_table[1] = Addr1;
  assign addr_table[2] = Addr2;
  assign addr_table[3] = Addr3;

  // Lowest set index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    pick_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (Pending[i]) pick_idx = IdxBits'(i);
    end
  end

  assign pick_onehot = NumReq'(1) << pick_idx;
  assign grant_now   = (state == IDLE) && !Mute && (|Pending) && EndofScore;
  assign timeout_hit = (state == WAIT_BEGIN) && EndofScore &&
                       (timeout_cnt == 8'(TimeoutCycles - 1));
  assign play_done   = (state == PLAY) && EndofScore;
  // A zero gap still spends one cycle in GAP.
  assign gap_done    = (state == GAP) && (({1'b0, gap_cnt} + 17'd1) >= 17'(GapCycles));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (grant_now) state_next = START;
      START:      state_next = WAIT_BEGIN;
      WAIT_BEGIN: begin
        if (!EndofScore)     state_next = PLAY;
        else if (timeout_hit) state_next = GAP;
      end
      PLAY:       if (play_done) state_next = GAP;
      GAP:        if (gap_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    Start = (state == START);
    Busy  = (state != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      StartAddress <= '0;
      Grant        <= '0;
      Pending      <= '0;
      Timeout      <= 1'b0;
      timeout_cnt  <= '0;
      gap_cnt      <= '0;
    end else begin
      Timeout <= timeout_hit;

      // The granted bit is masked after the OR so a same-cycle request on it is absorbed.
      if (Mute) Pending <= '0;
      else      Pending <= (Pending | Request) & ~(grant_now ? pick_onehot : '0);

      if (grant_now) begin
        Grant        <= pick_onehot;
        StartAddress <= addr_table[pick_idx];
      end else if (play_done || timeout_hit) begin
        Grant <= '0;
      end

      if (state == START)
        timeout_cnt <= '0;
      else if ((state == WAIT_BEGIN) && EndofScore && !timeout_hit)
        timeout_cnt <= timeout_cnt + 8'd1;

      if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Random-stimulus bench: a timeline reference model predicts each Start/Timeout,
// a monitor pops and compares them and checks the status outputs every cycle.
module tb_sound_event_scheduler;

  localparam int TO  = 8;
  localparam int GAP = 16;
  localparam int GP  = (GAP == 0) ? 1 : GAP;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Request = '0;
  logic       Mute = 1'b0;
  logic       EndofScore = 1'b1;
  logic       Start;
  logic [4:0] StartAddress;
  logic [3:0] Grant;
  logic       Busy;
  logic [3:0] Pending;
  logic       Timeout;

  sound_event_scheduler #(.TimeoutCycles(TO), .GapCycles(GAP)) dut (
    .Clock(Clock), .Reset(Reset), .Request(Request), .Mute(Mute),
    .EndofScore(EndofScore), .Start(Start), .StartAddress(StartAddress),
    .Grant(Grant), .Busy(Busy), .Pending(Pending), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         cyc;
    logic [4:0] addr;
    logic [3:0] grant;
  } start_t;

  start_t     sq[$];
  int         tq[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic       mon_en = 1'b0;

  // Reference model: pending set plus the timeline of the current effect.
  logic [3:0] m_pend = '0;
  logic [4:0] m_addr = '0;
  logic [3:0] g_hot = '0;
  int         g_from = 0, g_to = 0;
  int         idle_from = 0;
  int         lo_from = 1, lo_to = 0;
  int         force_d = 0, force_p = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] score_addr(input int k);
    return 5'(8 * k);
  endfunction

  // Advance the model over the edge that just happened, using the inputs the DUT saw.
  task automatic model_step();
    logic [3:0] old;
    int         k, d, p, s;
    bit         to;
    old = m_pend;
    k = -1;
    if ((cyc - 1) >= idle_from && !Mute && old != 0 && EndofScore)
      for (int i = 3; i >= 0; i--) if (old[i]) k = i;
    m_pend = Mute ? 4'b0 : (old | Request);
    if (k >= 0) begin
      s = cyc;
      m_pend[k] = 1'b0;
      m_addr = score_addr(k);
      g_hot = 4'(1 << k);
      g_from = s;
      if (force_p > 0) begin
        to = 1'b0; d = force_d; p = force_p;
      end else begin
        to = ($urandom_range(0, 5) == 0);
        d = $urandom_range(0, TO - 1);
        p = $urandom_range(1, 6);
      end
      if (to) begin
        lo_from = 1; lo_to = 0;
        g_to = s + 1 + TO;
        idle_from = s + 1 + TO + GP;
        tq.push_back(s + 1 + TO);
      end else begin
        lo_from = s + 1 + d;
        lo_to = s + d + p;
        g_to = s + 2 + d + p;
        idle_from = s + 2 + d + p + GP;
      end
      sq.push_back('{cyc: s, addr: score_addr(k), grant: 4'(1 << k)});
    end
  endtask

  // Called just after a rising edge: drive this cycle's inputs, then take the next edge.
  task automatic tick(input logic [3:0] r, input logic m);
    Request = r;
    Mute = m;
    if (cyc >= lo_from && cyc <= lo_to) EndofScore = 1'b0;
    else if (cyc >= idle_from && $urandom_range(0, 4) == 0) EndofScore = 1'b0;
    else EndofScore = 1'b1;
    @(posedge Clock);
    cyc++;
    model_step();
    #1;
  endtask

  task automatic model_reset();
    m_pend = '0; m_addr = '0; g_hot = '0;
    g_from = 0; g_to = 0; idle_from = 0;
    lo_from = 1; lo_to = 0;
    force_d = 0; force_p = 0;
    sq.delete();
    tq.delete();
  endtask

  always @(negedge Clock) begin
    if (mon_en) begin
      bit     exp_start, exp_to;
      start_t e;
      chk("pending", 32'(Pending), 32'(m_pend));
      chk("busy", 32'(Busy), 32'(cyc < idle_from));
      chk("grant", 32'(Grant), (cyc >= g_from && cyc < g_to) ? 32'(g_hot) : 32'd0);
      chk("start_address", 32'(StartAddress), 32'(m_addr));
      exp_start = (sq.size() > 0) && (sq[0].cyc == cyc);
      chk("start", 32'(Start), 32'(exp_start));
      if (Start && sq.size() > 0) begin
        e = sq.pop_front();
        chk("start_cycle", 32'(cyc), 32'(e.cyc));
        chk("start_addr_txn", 32'(StartAddress), 32'(e.addr));
        chk("start_grant_txn", 32'(Grant), 32'(e.grant));
        $display("txn start cyc=%0d addr=%0d grant=%b", cyc, StartAddress, Grant);
      end else if (exp_start) begin
        void'(sq.pop_front());
      end
      exp_to = (tq.size() > 0) && (tq[0] == cyc);
      chk("timeout", 32'(Timeout), 32'(exp_to));
      if (exp_to) begin
        void'(tq.pop_front());
        $display("txn timeout cyc=%0d grant=%b", cyc, Grant);
      end
    end
  end

  initial begin
    int         mute_left;
    logic [3:0] r;
    logic       m;
    mute_left = 0;

    @(posedge Clock);
    #2;
    chk("rst_start", 32'(Start), 32'd0);
    chk("rst_addr", 32'(StartAddress), 32'd0);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_pending", 32'(Pending), 32'd0);
    chk("rst_timeout", 32'(Timeout), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    cyc = 0;
    mon_en = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      m = 1'b0;
      if (mute_left > 0) begin
        mute_left--;
        m = 1'b1;
      end else if (n > 20 && $urandom_range(0, 79) == 0) begin
        mute_left = $urandom_range(2, 10);
      end
      if (n == 0) r = 4'b0100;
      if (n == 1) r = 4'b1010;
      if (n >= 2900) begin
        r = '0;
        m = 1'b0;
      end
      tick(r, m);
    end
    chk("start_queue_drained", 32'(sq.size()), 32'd0);
    chk("timeout_queue_drained", 32'(tq.size()), 32'd0);

    // Reset in the middle of a long playback.
    force_d = 0;
    force_p = 30;
    tick(4'b0010, 1'b0);
    for (int n = 0; n < 8; n++) tick(4'b0000, 1'b0);
    chk("pre_reset_busy", 32'(Busy), 32'd1);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    chk("arst_start", 32'(Start), 32'd0);
    chk("arst_addr", 32'(StartAddress), 32'd0);
    chk("arst_grant", 32'(Grant), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_pending", 32'(Pending), 32'd0);
    chk("arst_timeout", 32'(Timeout), 32'd0);
    @(posedge Clock);
    cyc++;
    #1;
    Reset = 1'b0;
    tick(4'b1000, 1'b0);
    for (int n = 0; n < 80; n++) tick(4'b0000, 1'b0);
    chk("final_start_queue_drained", 32'(sq.size()), 32'd0);
    chk("final_timeout_queue_drained", 32'(tq.size()), 32'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
